fp_mul_pipe_checker: RTL

- Sequential, parametrised checker bound alongside a pipelined floating-point multiplier with fixed latency.
- Classifies each accepted operand pair and predicts the result class and sign, with subnormals flushed to zero.
- Carries each prediction through a delay line and compares it against the multiplier output when that output emerges.
- Reports the first error with a code, keeps statistics counters, and generalises the single-precision combinational checks to any format width and pipeline depth.

---
 rtl/fp_mul_chk_pkg.sv | 57 +++++
 rtl/fp_mul_chk_delay.sv | 47 ++++
 rtl/fp_mul_pipe_checker.sv | 100 ++++++++++
 3 files changed

// File: rtl/fp_mul_chk_pkg.sv
// Shared types and helpers for fp_mul_pipe_checker: operand/result classes,
// error codes and the width-generic classification function.
package fp_mul_chk_pkg;

  // Widest exponent/fraction accepted by fp_classify; callers zero-extend.
  localparam int unsigned MAX_EXP_W = 32;
  localparam int unsigned MAX_FRC_W = 128;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_INF  = 3'd1,
    CLS_NAN  = 3'd2,
    CLS_NORM = 3'd3,
    CLS_ANY  = 3'd4
  } fp_class_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CLASS   = 3'd1,
    ERR_SIGN    = 3'd2,
    ERR_UNEXP   = 3'd3,
    ERR_MISSING = 3'd4,
    ERR_FLAG    = 3'd5
  } err_code_e;

  typedef struct packed {
    fp_class_e cls;
    logic      sgn;
  } pred_t;

  // Exponent 0 is ZERO, so subnormals are flushed.
  function automatic fp_class_e fp_classify(input logic [MAX_EXP_W-1:0] e,
                                            input logic [MAX_FRC_W-1:0] f,
                                            input int unsigned          exp_w);
    logic [MAX_EXP_W-1:0] ones;
    ones = {MAX_EXP_W{1'b1}} >> (MAX_EXP_W - exp_w);
    if (e == '0)
      return CLS_ZERO;
    else if (e == ones)
      return (f == '0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

  function automatic fp_class_e fp_predict(input fp_class_e cx, input fp_class_e cy);
    if (cx == CLS_NAN || cy == CLS_NAN ||
        (cx == CLS_INF && cy == CLS_ZERO) || (cx == CLS_ZERO && cy == CLS_INF))
      return CLS_NAN;
    else if (cx == CLS_INF || cy == CLS_INF)
      return CLS_INF;
    else if (cx == CLS_ZERO || cy == CLS_ZERO)
      return CLS_ZERO;
    else
      return CLS_ANY;
  endfunction

endpackage

// File: rtl/fp_mul_chk_delay.sv
// Generic valid+payload shift line of LATENCY stages with a population count
// of the valid stages.
module fp_mul_chk_delay #(
  parameter int unsigned LATENCY = 3,
  parameter int unsigned PAY_W   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [PAY_W-1:0]                 in_data,
  output logic                             tail_valid,
  output logic [PAY_W-1:0]                 tail_data,
  output logic [$clog2(LATENCY+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(LATENCY+1);

  logic [LATENCY-1:0] vld;
  logic [PAY_W-1:0]   dat [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int unsigned i = 1; i < LATENCY; i++)
        vld[i] <= vld[i-1];
    end
  end

  // Payload needs no reset: it is only ever read qualified by its valid bit.
  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int unsigned i = 1; i < LATENCY; i++)
      dat[i] <= dat[i-1];
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < LATENCY; i++)
      count = count + CW'(vld[i]);
  end

  assign tail_valid = vld[LATENCY-1];
  assign tail_data  = dat[LATENCY-1];

endmodule

// File: rtl/fp_mul_pipe_checker.sv
// Class/sign checker for a fixed-latency pipelined FP multiplier.
// Define FP_MUL_CHK_FLAGS_EN to also flag ovrf/udrf on special-input results.
module fp_mul_pipe_checker
  import fp_mul_chk_pkg::*;
#(
  parameter int unsigned EXP_W   = 8,
  parameter int unsigned FRC_W   = 23,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [EXP_W+FRC_W:0]             fp_X,
  input  logic [EXP_W+FRC_W:0]             fp_Y,
  input  logic [2:0]                       r_mode,
  input  logic                             out_valid,
  input  logic [EXP_W+FRC_W:0]             fp_Z,
  input  logic                             ovrf,
  input  logic                             udrf,
  output logic                             err,
  output logic [2:0]                       err_code,
  output logic [$clog2(LATENCY+1)-1:0]     pending,
  output logic [CNT_W-1:0]                 chk_cnt,
  output logic [CNT_W-1:0]                 err_cnt
);

  localparam int unsigned W = 1 + EXP_W + FRC_W;

  fp_class_e  cx, cy, res_cls;
  pred_t      pred_in, tail_p;
  logic       tail_v;
  logic       checked, e_missing, e_unexp, e_class, e_sign, e_flag;
  err_code_e  cur_err, code_q;
  logic       unused_inputs;

  assign unused_inputs = ^{r_mode, ovrf, udrf};

  always_comb begin
    cx = fp_classify(MAX_EXP_W'(fp_X[W-2 -: EXP_W]), MAX_FRC_W'(fp_X[FRC_W-1:0]), EXP_W);
    cy = fp_classify(MAX_EXP_W'(fp_Y[W-2 -: EXP_W]), MAX_FRC_W'(fp_Y[FRC_W-1:0]), EXP_W);
    pred_in.cls = fp_predict(cx, cy);
    pred_in.sgn = fp_X[W-1] ^ fp_Y[W-1];
  end

  fp_mul_chk_delay #(
    .LATENCY (LATENCY),
    .PAY_W   ($bits(pred_t))
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (pred_in),
    .tail_valid (tail_v),
    .tail_data  (tail_p),
    .count      (pending)
  );

  always_comb begin
    res_cls   = fp_classify(MAX_EXP_W'(fp_Z[W-2 -: EXP_W]), MAX_FRC_W'(fp_Z[FRC_W-1:0]), EXP_W);
    checked   = tail_v & out_valid;
    e_missing = tail_v & ~out_valid;
    e_unexp   = out_valid & ~tail_v;
    e_class   = checked && (tail_p.cls != CLS_ANY) && (res_cls != tail_p.cls);
    e_sign    = checked && (tail_p.cls != CLS_NAN) && (fp_Z[W-1] != tail_p.sgn);
`ifdef FP_MUL_CHK_FLAGS_EN
    e_flag    = checked && (tail_p.cls != CLS_ANY) && (ovrf || udrf);
`else
    e_flag    = 1'b0;
`endif
    cur_err = ERR_NONE;
    if (e_missing)    cur_err = ERR_MISSING;
    else if (e_unexp) cur_err = ERR_UNEXP;
    else if (e_class) cur_err = ERR_CLASS;
    else if (e_sign)  cur_err = ERR_SIGN;
    else if (e_flag)  cur_err = ERR_FLAG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      code_q  <= ERR_NONE;
      chk_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (cur_err != ERR_NONE) begin
        err <= 1'b1;
        if (code_q == ERR_NONE)
          code_q <= cur_err;
        if (err_cnt != '1)
          err_cnt <= err_cnt + CNT_W'(1);
      end
      if (checked && chk_cnt != '1)
        chk_cnt <= chk_cnt + CNT_W'(1);
    end
  end

  assign err_code = code_q;

endmodule
